// File: rtl/bnn_pkg.sv
// Shared types and widths for the BNN weight-streaming front end.
package bnn_pkg;
    localparam int NIB_W           = 4;
    localparam int BYTE_W          = 8;
    localparam int DEF_NUM_NEURONS = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;
endpackage

// File: rtl/bnn_byte_fifo.sv
// Small synchronous byte FIFO with flush; read data is the current head entry.
module bnn_byte_fifo
    import bnn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [BYTE_W-1:0]            push_data,
    input  logic                         pop,
    output logic [BYTE_W-1:0]            pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [BYTE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Depth is a power of two, so the level MSB alone marks full.
    assign full     = level[AW];
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/bnn_weight_loader.sv
// Buffers weight bytes and streams them to the BNN core as low/high nibble pairs,
// one session of NUM_NEURONS bytes at a time.
module bnn_weight_loader
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_en,
    output logic [NIB_W-1:0]  weight_nib,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [NIB_W-1:0]  neuron_idx
);
    localparam int                LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [NIB_W-1:0]  LAST_CNT = NIB_W'(NUM_NEURONS);
    localparam logic [LW-1:0]     DEPTH_L  = LW'(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [NIB_W-1:0]   accepted_q, accepted_d;
    logic [NIB_W-1:0]   idx_d, nib_d;
    logic               abort_pend_q, abort_pend_d;
    logic               exit_abort, load_d, busy_d, ready_d;
    logic               push, pop, flush;
    logic               fifo_full, fifo_empty;
    logic [BYTE_W-1:0]  fifo_data, byte_q;
    logic [LW-1:0]      level, level_d;

    assign push = in_valid && in_ready && !fifo_full;

    bnn_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_comb begin
        state_d      = state_q;
        accepted_d   = accepted_q;
        idx_d        = neuron_idx;
        nib_d        = weight_nib;
        abort_pend_d = abort_pend_q;
        exit_abort   = 1'b0;
        load_d       = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        if (push) accepted_d = accepted_q + NIB_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d      = ST_WAIT;
                    flush        = 1'b1;
                    accepted_d   = '0;
                    idx_d        = '0;
                    abort_pend_d = 1'b0;
                end
            end
            ST_WAIT: begin
                abort_pend_d = abort_pend_q || abort;
                if (abort_pend_d) begin
                    state_d    = ST_DONE;
                    exit_abort = 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_LO;
                    load_d  = 1'b1;
                    nib_d   = fifo_data[NIB_W-1:0];
                end
            end
            ST_LO: begin
                // A pair is never split: abort only takes effect after HI.
                abort_pend_d = abort_pend_q || abort;
                state_d      = ST_HI;
                load_d       = 1'b1;
                nib_d        = byte_q[BYTE_W-1:NIB_W];
            end
            ST_HI: begin
                abort_pend_d = abort_pend_q || abort;
                idx_d        = neuron_idx + NIB_W'(1);
                if (idx_d == LAST_CNT) begin
                    state_d = ST_DONE;
                end else if (abort_pend_d) begin
                    state_d    = ST_DONE;
                    exit_abort = 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_LO;
                    load_d  = 1'b1;
                    nib_d   = fifo_data[NIB_W-1:0];
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                flush        = 1'b1;
                abort_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // in_ready is registered, so it is evaluated on next-cycle values.
        busy_d  = (state_d != ST_IDLE);
        level_d = flush ? '0 : level + LW'(push) - LW'(pop);
        ready_d = busy_d && (state_d != ST_DONE) && (level_d != DEPTH_L) &&
                  (accepted_d < LAST_CNT) && !abort_pend_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            accepted_q   <= '0;
            abort_pend_q <= 1'b0;
            in_ready     <= 1'b0;
            load_en      <= 1'b0;
            weight_nib   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            neuron_idx   <= '0;
        end else begin
            state_q      <= state_d;
            accepted_q   <= accepted_d;
            abort_pend_q <= abort_pend_d;
            in_ready     <= ready_d;
            load_en      <= load_d;
            weight_nib   <= nib_d;
            busy         <= busy_d;
            done         <= (state_d == ST_DONE) && !exit_abort;
            aborted      <= (state_d == ST_DONE) && exit_abort;
            neuron_idx   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) byte_q <= fifo_data;
    end
endmodule

// File: tb/tb_bnn_weight_loader.sv
// Randomized bench for bnn_weight_loader against a per-byte timing model of the nibble stream.
module tb_bnn_weight_loader;
    localparam int NN    = 12;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, start, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, load_en, busy, done, aborted;
    logic [3:0] weight_nib, neuron_idx;

    always #5 clk = ~clk;

    bnn_weight_loader #(.NUM_NEURONS(NN), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load_en    (load_en),
        .weight_nib (weight_nib),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .neuron_idx (neuron_idx)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: per accepted byte k, t[k] is the edge from which its low nibble is shown.
    bit         sess    = 1'b0;
    int         e_abort = -1;
    int         nacc    = 0;
    int         t [16];
    logic [7:0] b [16];
    bit         exp_rdy = 1'b0;

    int ld_cnt, dut_acc, n_done, n_abt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit valid_k(input int k);
        return (k < nacc) && (e_abort < 0 || t[k] < e_abort);
    endfunction

    function automatic int nvalid();
        int n = 0;
        for (int k = 0; k < nacc; k++) if (valid_k(k)) n++;
        return n;
    endfunction

    function automatic bit is_normal();
        return (nacc == NN) && (e_abort < 0 || t[NN-1] < e_abort);
    endfunction

    // Edge at which the DONE cycle begins, or -1 while still unknown.
    function automatic int end_edge();
        int nv;
        if (is_normal()) return t[NN-1] + 2;
        if (e_abort < 0) return -1;
        nv = nvalid();
        if (nv == 0) return e_abort;
        return (t[nv-1] + 2 > e_abort) ? t[nv-1] + 2 : e_abort;
    endfunction

    function automatic bit session_over();
        int d;
        d = end_edge();
        return sess && d >= 0 && cyc >= d + 1;
    endfunction

    task automatic check_outputs();
        int d, idx, popped;
        bit busy_e, ld_e;
        logic [3:0] nib_e;
        if (!sess) begin
            exp_rdy = 1'b0;
            chk("busy", busy, 0);
            chk("load_en", load_en, 0);
            chk("done", done, 0);
            chk("aborted", aborted, 0);
            chk("in_ready", in_ready, 0);
            chk("neuron_idx", neuron_idx, 0);
            chk("weight_nib", weight_nib, 0);
            return;
        end
        d      = end_edge();
        busy_e = (d < 0) || (cyc <= d);
        ld_e   = 1'b0;
        nib_e  = '0;
        idx    = 0;
        popped = 0;
        for (int k = 0; k < nacc; k++) begin
            if (valid_k(k)) begin
                if (t[k] == cyc)     begin ld_e = 1'b1; nib_e = b[k][3:0]; end
                if (t[k] + 1 == cyc) begin ld_e = 1'b1; nib_e = b[k][7:4]; end
                if (t[k] + 2 <= cyc) idx++;
                if (t[k] <= cyc)     popped++;
            end
        end
        exp_rdy = busy_e && (cyc != d) && (nacc - popped < DEPTH) && (nacc < NN) &&
                  !(e_abort >= 0 && cyc >= e_abort);
        chk("busy", busy, busy_e);
        chk("load_en", load_en, ld_e);
        if (ld_e) chk("weight_nib", weight_nib, nib_e);
        chk("neuron_idx", neuron_idx, idx);
        chk("done", done, (cyc == d) && is_normal());
        chk("aborted", aborted, (cyc == d) && !is_normal());
        chk("in_ready", in_ready, exp_rdy);
    endtask

    task automatic tick(output bit took);
        bit start_now, abort_now;
        int d;
        d         = sess ? end_edge() : -1;
        took      = in_valid && exp_rdy && !reset;
        start_now = start && !abort && !reset && (!sess || (d >= 0 && cyc >= d + 1));
        abort_now = abort && !reset && sess && (d < 0 || cyc < d) && e_abort < 0;
        if (in_valid && in_ready && !reset) dut_acc++;
        @(posedge clk);
        cyc++;
        if (reset) begin
            sess = 1'b0; nacc = 0; e_abort = -1;
        end else begin
            if (start_now) begin sess = 1'b1; nacc = 0; e_abort = -1; end
            if (took && nacc < 16) begin
                b[nacc] = in_data;
                if (nacc == 0 || cyc + 1 > t[nacc-1] + 2) t[nacc] = cyc + 1;
                else                                      t[nacc] = t[nacc-1] + 2;
                nacc++;
            end
            if (abort_now) e_abort = cyc;
        end
        #1;
        check_outputs();
        if (load_en) ld_cnt++;
        if (done)    n_done++;
        if (aborted) n_abt++;
    endtask

    task automatic run_session(input int n_offer, input int prob, input int gap_after,
                               input int gap_len, input int abort_lo_k, input int abort_rel,
                               input int rst_hi_k, input bit poke_start);
        logic [7:0] src [16];
        int oi, gap_left, c0;
        bit hold, took, stop;
        for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
        src[0] = 8'hFF;
        src[1] = 8'h0F;
        ld_cnt = 0; dut_acc = 0; n_done = 0; n_abt = 0;
        oi = 0; gap_left = 0; hold = 1'b0; stop = 1'b0;
        start = 1'b1;
        tick(took);
        start = 1'b0;
        c0 = cyc;
        for (int n = 0; n < 400 && !stop; n++) begin
            if (gap_left > 0) begin
                in_valid = 1'b0;
                gap_left--;
            end else if (hold || (oi < n_offer && $urandom_range(99) < prob)) begin
                in_valid = 1'b1;
                in_data  = src[oi];
                hold     = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            abort = (abort_lo_k >= 0 && valid_k(abort_lo_k) && t[abort_lo_k] == cyc) ||
                    (abort_rel >= 0 && cyc - c0 == abort_rel);
            reset = rst_hi_k >= 0 && valid_k(rst_hi_k) && t[rst_hi_k] + 1 == cyc;
            start = poke_start && (cyc - c0 == 6 || cyc - c0 == 7);
            tick(took);
            if (took) begin
                oi++;
                hold = 1'b0;
                if (oi == gap_after) gap_left = gap_len;
            end
            if (reset || session_over()) stop = 1'b1;
        end
        in_valid = 1'b0; abort = 1'b0; reset = 1'b0; start = 1'b0;
        chk("session_end", busy, 0);
    endtask

    initial begin
        bit took;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) tick(took);
        reset = 1'b0;
        repeat (2) tick(took);

        // Back-to-back with 14 bytes offered and start pulsed while busy.
        run_session(14, 100, -1, 0, -1, -1, -1, 1'b1);
        chk("b2b_accepted", dut_acc, 12);
        chk("b2b_load_cycles", ld_cnt, 24);
        chk("b2b_final_idx", neuron_idx, 12);
        chk("b2b_done_pulses", n_done, 1);
        chk("b2b_abort_pulses", n_abt, 0);

        // Starvation gap after byte 3.
        run_session(12, 100, 3, 5, -1, -1, -1, 1'b0);
        chk("gap_load_cycles", ld_cnt, 24);
        chk("gap_done_pulses", n_done, 1);

        // Abort during the low nibble of byte 5.
        run_session(12, 100, -1, 0, 4, -1, -1, 1'b0);
        chk("abort_load_cycles", ld_cnt, 10);
        chk("abort_final_idx", neuron_idx, 5);
        chk("abort_pulses", n_abt, 1);
        chk("abort_done_pulses", n_done, 0);

        // start and abort together in IDLE must be ignored.
        start = 1'b1; abort = 1'b1;
        tick(took);
        start = 1'b0; abort = 1'b0;
        repeat (3) tick(took);
        chk("idle_start_abort_busy", busy, 0);

        // Reset during the high nibble of byte 7, then a clean reload.
        run_session(12, 100, -1, 0, -1, -1, 6, 1'b0);
        chk("rst_load_en", load_en, 0);
        tick(took);
        run_session(12, 100, -1, 0, -1, -1, -1, 1'b0);
        chk("reload_load_cycles", ld_cnt, 24);
        chk("reload_final_idx", neuron_idx, 12);

        for (int r = 0; r < 8; r++) begin
            run_session(12 + $urandom_range(2), $urandom_range(30, 100), -1, 0, -1,
                        ($urandom_range(1) == 1) ? $urandom_range(3, 30) : -1, -1, 1'b0);
            chk("rand_pulses", n_done + n_abt, 1);
            repeat (2) tick(took);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/bnn_weight_loader.md
# bnn_weight_loader

Upstream weight-streaming stage for the 8-8-4 BNN core.
- Accepts whole 8-bit neuron weight bytes over a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte into the core's two-cycle nibble protocol: low nibble first, then high nibble, with load enable high on both cycles.
- Counts neurons, so a session delivers exactly `NUM_NEURONS` bytes, never splits a nibble pair, and reports completion.

## Interface
Parameters:
- `NUM_NEURONS`, 12: bytes per load session; one per neuron, layer 1 then layer 2.
- `FIFO_DEPTH`, 4: byte buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  — the only clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high; clears all state.
- `start`  in  1  — begins a session; honoured only in IDLE.
- `abort`  in  1  — ends the session early, at a pair boundary.
- `in_data`  in  8  — weight byte; bit i pairs with input i.
- `in_valid`  in  1  — `in_data` is valid.
- `in_ready`  out  1  — byte accepted on an edge where `in_valid && in_ready`.
- `load_en`  out  1  — drives core `uio_in[3]`.
- `weight_nib`  out  4  — drives core `uio_in[7:4]`.
- `busy`  out  1  — a session is active; held high through DONE.
- `done`  out  1  — one-cycle pulse when the session ends normally.
- `aborted`  out  1  — one-cycle pulse when the session ends via abort.
- `neuron_idx`  out  4  — count of fully emitted bytes in this session.

## Operation
- FSM states: IDLE, WAIT, LO, HI, DONE. All outputs are registered.
- IDLE:
  - `start=1` and `abort=0` → WAIT. Clears both counters and the FIFO.
  - `start` in any other state is ignored.
- WAIT:
  - FIFO non-empty → pop one byte → LO.
  - Otherwise stay; `load_en=0`.
- LO: `load_en=1`, `weight_nib=byte[3:0]` → HI, unconditionally.
- HI: `load_en=1`, `weight_nib=byte[7:4]`; increment `neuron_idx`. Next state:
  - new count == `NUM_NEURONS` → DONE;
  - else abort pending → DONE with abort flag set;
  - else FIFO non-empty → pop → LO (back-to-back);
  - else → WAIT.
- DONE: `load_en=0`. Pulses `done` or `aborted`, never both. Flushes the FIFO. → IDLE.
- Acceptance counter: counts bytes accepted this session.
  - `in_ready = busy && !fifo_full && accepted < NUM_NEURONS && !abort_pending && state != DONE`.
  - A 13th byte is never accepted.
- Abort:
  - Latched as `abort_pending` in WAIT, LO or HI.
  - In WAIT → DONE on the next edge.
  - In LO → HI still completes the pair, then → DONE.
- `weight_nib` holds its last value when `load_en=0`. Its value there is don't-care for the core; the bench checks it only while `load_en=1`.
- Core coupling:
  - The core's nibble phase and neuron index reset only with the core's own reset, and they wrap.
  - This block guarantees an even number of `load_en` cycles per session.
  - System integration ties this block's `reset` to the core reset.
  - Reloading requires a core reset between sessions.

## Timing
- Reset values: `in_ready`, `load_en`, `weight_nib`, `busy`, `done`, `aborted`, `neuron_idx` are all 0; state IDLE; FIFO empty.
- `start` sampled on edge S → `busy=1` from S+1.
- Byte accepted on edge N with FIFO empty and state WAIT:
  - FSM sees it on edge N+1; low nibble is presented from N+1.
  - High nibble from N+2.
- Throughput: one byte per 2 cycles. `load_en` stays high continuously while the FIFO stays non-empty.
- Simultaneous FIFO push and pop when full: push refused (`in_ready=0`). When empty: pop refused; pop uses registered occupancy.
- End of session:
  - After the final HI cycle: DONE for 1 cycle (`done`/`aborted`=1, `load_en=0`).
  - `busy` falls on the following edge.
  - `start` is accepted again from IDLE.
- Reset mid-session: all outputs return to reset values on that edge, including `load_en=0`.

## Structure
- Package `bnn_pkg`:
  - FSM state typedef (IDLE/WAIT/LO/HI/DONE);
  - `NIB_W=4`, `BYTE_W=8`;
  - default `NUM_NEURONS=12`.
- Sub-module `bnn_byte_fifo`:
  - synchronous FIFO, `FIFO_DEPTH`×8;
  - interfaces: push/pop, full/empty, flush.
- Top level holds the FSM and both counters.

## Test plan
- Back-to-back load: start; 12 bytes with `in_valid` held (0xFF,0x0F,…).
  - Expect 24 contiguous `load_en` cycles, nibbles LO/HI in order.
  - `done` 1 cycle after the last HI; `neuron_idx`=12.
  - Core weights match byte-for-byte.
- Starvation: gap of 5 cycles after byte 3.
  - Expect `load_en=0` during the gap, never between a LO and its HI.
  - Total 24 `load_en` cycles.
- Abort during LO of byte 5.
  - Expect HI still emitted; `neuron_idx`=5; `aborted` pulse; no `done`.
  - 10 `load_en` cycles total; `in_ready` low from the cycle after abort.
- Overflow: offer 14 bytes.
  - Exactly 12 accepted; `in_ready` stays 0 after the 12th; `in_data` of bytes 13-14 never appears.
- Reset on the cycle of a HI nibble.
  - All outputs 0 next edge; FIFO empty.
  - Fresh start + 12 bytes loads correctly after core reset.
- `start` asserted while busy, and `start`+`abort` together in IDLE.
  - Both ignored: no state change, no `in_ready`.
